// File: rtl/pio_gpio_infilter.sv
// GPIO input conditioning ahead of the PIO gpio_in port: per-pin synchronizer,
// prescaled debounce filter, registered output and rise/fall edge pulses.

module pio_gpio_infilter_pin #(
    parameter int CNTW        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            raw,
    input  logic            sync_bypass,
    input  logic            filt_en,
    input  logic [CNTW-1:0] filt_len,
    input  logic            tick,
    output logic            gpio_in,
    output logic            rise_pulse,
    output logic            fall_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample;
    logic                   stable;
    logic                   gpio_q;
    logic [CNTW-1:0]        cnt;
    logic [CNTW:0]          cnt_inc;
    logic                   len_hit;

    // The chain keeps shifting while bypassed so re-enabling it never exposes stale data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end

    assign sample = sync_bypass ? raw : sync_q[SYNC_STAGES-1];

    // One extra bit so cnt+1 can't wrap; >= lets a lowered filt_len act on the next tick.
    assign cnt_inc = {1'b0, cnt} + {{CNTW{1'b0}}, 1'b1};
    assign len_hit = cnt_inc >= {1'b0, filt_len};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (!filt_en) begin
            stable <= sample;
            cnt    <= '0;
        end else if (sample == stable) begin
            cnt    <= '0;
        end else if (tick) begin
            if (len_hit) begin
                stable <= sample;
                cnt    <= '0;
            end else begin
                cnt    <= cnt_inc[CNTW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) gpio_q <= 1'b0;
        else       gpio_q <= stable;
    end

    assign gpio_in    = stable;
    assign rise_pulse =  stable & ~gpio_q;
    assign fall_pulse = ~stable &  gpio_q;

endmodule

module pio_gpio_infilter #(
    parameter int NPIN        = 32,
    parameter int CNTW        = 8,
    parameter int PSW         = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NPIN-1:0] gpio_raw,
    input  logic            sync_bypass,
    input  logic [NPIN-1:0] filt_en,
    input  logic [CNTW-1:0] filt_len,
    input  logic [PSW-1:0]  prescale,
    output logic [NPIN-1:0] gpio_in,
    output logic [NPIN-1:0] rise_pulse,
    output logic [NPIN-1:0] fall_pulse,
    output logic            edge_any
);

    logic [PSW-1:0] pcnt;
    logic           tick;

    // >= compare: shrinking prescale mid-count fires on the next cycle instead of wrapping.
    assign tick = pcnt >= prescale;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     pcnt <= '0;
        else if (tick) pcnt <= '0;
        else           pcnt <= pcnt + {{(PSW-1){1'b0}}, 1'b1};
    end

    for (genvar i = 0; i < NPIN; i++) begin : g_pin
        pio_gpio_infilter_pin #(
            .CNTW        (CNTW),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_pin (
            .clk         (clk),
            .reset       (reset),
            .raw         (gpio_raw[i]),
            .sync_bypass (sync_bypass),
            .filt_en     (filt_en[i]),
            .filt_len    (filt_len),
            .tick        (tick),
            .gpio_in     (gpio_in[i]),
            .rise_pulse  (rise_pulse[i]),
            .fall_pulse  (fall_pulse[i])
        );
    end

    assign edge_any = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_pio_gpio_infilter.sv
// Self-checking bench: directed scenarios plus random toggling against a
// history-based reference model of the conditioning rules.

module tb_pio_gpio_infilter;

    localparam int NPIN = 32;
    localparam int S    = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [NPIN-1:0] gpio_raw;
    logic            sync_bypass;
    logic [NPIN-1:0] filt_en;
    logic [7:0]      filt_len;
    logic [7:0]      prescale;
    logic [NPIN-1:0] gpio_in, rise_pulse, fall_pulse;
    logic            edge_any;

    int total = 0;
    int bad   = 0;

    pio_gpio_infilter #(.NPIN(NPIN), .CNTW(8), .PSW(8), .SYNC_STAGES(S)) dut (
        .clk         (clk),
        .reset       (reset),
        .gpio_raw    (gpio_raw),
        .sync_bypass (sync_bypass),
        .filt_en     (filt_en),
        .filt_len    (filt_len),
        .prescale    (prescale),
        .gpio_in     (gpio_in),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .edge_any    (edge_any)
    );

    always #5 clk = ~clk;

    // Reference model: raw history queue, tick counter, per-pin stable value and count.
    logic [NPIN-1:0] hist[$];
    logic [NPIN-1:0] m_st, m_prev;
    int              m_cnt[NPIN];
    int              m_pcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < S; k++) hist.push_back('0);
        m_st   = '0;
        m_prev = '0;
        m_pcnt = 0;
        for (int i = 0; i < NPIN; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step();
        logic            tk;
        logic [NPIN-1:0] smp;
        tk     = (m_pcnt >= int'(prescale));
        m_pcnt = tk ? 0 : m_pcnt + 1;
        // Without bypass the filter sees the raw value from S edges ago.
        smp    = sync_bypass ? gpio_raw : hist[S-1];
        hist.push_front(gpio_raw);
        void'(hist.pop_back());
        m_prev = m_st;
        for (int i = 0; i < NPIN; i++) begin
            if (!filt_en[i]) begin
                m_st[i] = smp[i]; m_cnt[i] = 0;
            end else if (smp[i] == m_st[i]) begin
                m_cnt[i] = 0;
            end else if (tk) begin
                if (m_cnt[i] + 1 >= int'(filt_len)) begin
                    m_st[i] = smp[i]; m_cnt[i] = 0;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) begin
            m_prev = m_st;
        end else begin
            model_step();
        end
        #1;
        chk("gpio_in",  gpio_in,    m_st);
        chk("rise",     rise_pulse, m_st & ~m_prev);
        chk("fall",     fall_pulse, ~m_st & m_prev);
        chk("edge_any", {31'b0, edge_any}, {31'b0, |(m_st ^ m_prev)});
    endtask

    initial begin
        int first, rises, glitch_seen;
        reset = 1'b1; gpio_raw = '0; sync_bypass = 1'b0; filt_en = '0;
        filt_len = 8'd0; prescale = 8'd0;
        model_reset();
        #1;
        chk("reset_gpio_in", gpio_in, 32'h0);
        chk("reset_edge",    {31'b0, edge_any}, 32'h0);
        step(); step();
        reset = 1'b0;
        repeat (4) step();

        // 1: unfiltered, synchronized: raw edge on pin 3 appears on cycle 3
        gpio_raw[3] = 1'b1;
        step(); step();
        chk("t1_in3_c2", {31'b0, gpio_in[3]}, 32'h0);
        step();
        chk("t1_in3_c3",   {31'b0, gpio_in[3]},    32'h1);
        chk("t1_rise3_c3", {31'b0, rise_pulse[3]}, 32'h1);
        chk("t1_edge_c3",  {31'b0, edge_any},      32'h1);
        step();
        chk("t1_rise3_c4", {31'b0, rise_pulse[3]}, 32'h0);
        chk("t1_edge_c4",  {31'b0, edge_any},      32'h0);

        // 2: filter len 4 rejects a 3-cycle glitch, then passes a held level after 6 cycles
        filt_en = 32'h1; filt_len = 8'd4; prescale = 8'd0;
        step(); step();
        gpio_raw[0] = 1'b1;
        repeat (3) step();
        gpio_raw[0] = 1'b0;
        glitch_seen = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (gpio_in[0] || rise_pulse[0]) glitch_seen = 1;
        end
        chk("t2_glitch", glitch_seen, 0);
        gpio_raw[0] = 1'b1;
        repeat (5) step();
        chk("t2_in0_c5", {31'b0, gpio_in[0]}, 32'h0);
        step();
        chk("t2_in0_c6",   {31'b0, gpio_in[0]},    32'h1);
        chk("t2_rise0_c6", {31'b0, rise_pulse[0]}, 32'h1);

        // 3: prescale 3, len 2: rise lands in [7,10] after the raw edge, single pulse
        filt_en = 32'h20; filt_len = 8'd2; prescale = 8'd3;
        step(); step();
        gpio_raw[5] = 1'b1;
        first = 0; rises = 0;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (gpio_in[5] && first == 0) first = k;
            rises += int'(rise_pulse[5]);
        end
        chk("t3_not_early", {31'b0, first >= 7}, 32'h1);
        chk("t3_not_late",  {31'b0, first != 0 && first <= 10}, 32'h1);
        chk("t3_one_rise",  rises, 1);

        // 4: bypass, filter off: fall on pin 31 shows up after a single cycle
        prescale = 8'd0; sync_bypass = 1'b1; filt_en = '0;
        gpio_raw[31] = 1'b1;
        step(); step();
        gpio_raw[31] = 1'b0;
        step();
        chk("t4_in31",   {31'b0, gpio_in[31]},    32'h0);
        chk("t4_fall31", {31'b0, fall_pulse[31]}, 32'h1);

        // 5: async reset mid-count clears outputs at once; release with pin 7 high
        sync_bypass = 1'b0; filt_en = '1; filt_len = 8'd200;
        gpio_raw = 32'h0000_0200;
        repeat (100) step();
        #3 reset = 1'b1;
        model_reset();
        #1;
        chk("t5_rst_in",   gpio_in,    32'h0);
        chk("t5_rst_rise", rise_pulse, 32'h0);
        chk("t5_rst_fall", fall_pulse, 32'h0);
        chk("t5_rst_edge", {31'b0, edge_any}, 32'h0);
        step(); step();
        gpio_raw = 32'h0000_0080; filt_en = '0;
        reset = 1'b0;
        rises = 0; first = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (rise_pulse[7]) begin rises++; first = k; end
        end
        chk("t5_one_rise", rises, 1);
        chk("t5_rise_cyc", first, 3);

        // 6: opposite edges on two pins in the same cycle
        gpio_raw = 32'h2;
        repeat (4) step();
        gpio_raw = 32'h1;
        step(); step(); step();
        chk("t6_rise0", {31'b0, rise_pulse[0]}, 32'h1);
        chk("t6_fall1", {31'b0, fall_pulse[1]}, 32'h1);
        chk("t6_edge",  {31'b0, edge_any},      32'h1);
        step();
        chk("t6_edge_off", {31'b0, edge_any}, 32'h0);

        // Random sparse toggling with occasional config changes
        for (int k = 0; k < 600; k++) begin
            if (k % 60 == 0) begin
                filt_en     = $urandom;
                filt_len    = 8'($urandom_range(0, 5));
                prescale    = 8'($urandom_range(0, 3));
                sync_bypass = 1'($urandom_range(0, 1));
            end
            if (k % 17 == 9) filt_len = 8'($urandom_range(0, 5));
            gpio_raw = gpio_raw ^ ($urandom & $urandom & $urandom & $urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
